// File: rtl/ethernet_irq_mod_pkg.sv
// Shared types and constants for the Ethernet interrupt moderator.
package ethernet_irq_mod_pkg;

  // Moderator FSM states; e_irq_holdoff is only reachable when the
  // post-acknowledge holdoff feature is compiled in.
  typedef enum logic [1:0] {
    e_irq_idle    = 2'd0,
    e_irq_count   = 2'd1,
    e_irq_fire    = 2'd2,
    e_irq_holdoff = 2'd3
  } irq_state_e;

  // Programmed timeout value that disables the timeout path.
  localparam int unsigned timeout_disabled_c = 0;

endpackage

// File: rtl/ethernet_irq_moderator_timer.sv
// irq_mod_timer: clear/enable saturating up-counter of parameterised width.
// Clear has priority over enable; the count sticks at all-ones.
module irq_mod_timer #(
  parameter int unsigned width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               enable_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_d;
  logic [width_p-1:0] count_q;

  // Next count: clear, else increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != {width_p{1'b1}})) begin
      count_d = count_q + width_p'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ethernet_irq_moderator.sv
// ethernet_irq_moderator: coalesces RX/TX completion events into a single
// interrupt raised on a packet-count threshold or a timeout, held until
// software acknowledges it.
// Optional feature: define ETHERNET_IRQ_HOLDOFF_EN to add a post-ack
// holdoff of holdoff_cycles_p cycles guaranteeing minimum interrupt spacing.
module ethernet_irq_moderator
  import ethernet_irq_mod_pkg::*;
#(
  parameter int unsigned count_width_p    = 8,
  parameter int unsigned timer_width_p    = 16,
  parameter int unsigned holdoff_cycles_p = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     rx_event_i,
  input  logic                     tx_event_i,
  input  logic                     irq_enable_i,
  input  logic [count_width_p-1:0] cfg_thresh_i,
  input  logic                     cfg_thresh_v_i,
  input  logic [timer_width_p-1:0] cfg_timeout_i,
  input  logic                     cfg_timeout_v_i,
  input  logic                     irq_ack_i,
  output logic                     irq_o,
  output logic [count_width_p-1:0] event_count_o
);

  irq_state_e state_d, state_q;
  logic       fire_d, fire_q;

  logic [count_width_p-1:0] thresh_d, thresh_q;
  logic [timer_width_p-1:0] timeout_d, timeout_q;
  logic [count_width_p-1:0] event_cnt_d, event_cnt_q;

  logic [1:0]               ev_sum;
  logic [count_width_p:0]   cnt_sum;
  logic [count_width_p-1:0] cnt_upd;
  logic                     ack_take;

  logic [timer_width_p-1:0] timer_q;
  logic                     timer_clear;
  logic                     timeout_hit;
  logic                     thresh_hit;

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------

  // Capture CSR writes; a zero threshold would fire on nothing, so store 1.
  always_comb begin
    thresh_d  = thresh_q;
    timeout_d = timeout_q;
    if (cfg_thresh_v_i) begin
      thresh_d = (cfg_thresh_i == '0) ? count_width_p'(1) : cfg_thresh_i;
    end
    if (cfg_timeout_v_i) begin
      timeout_d = cfg_timeout_i;
    end
  end

  // Config register state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      thresh_q  <= count_width_p'(1);
      timeout_q <= '0;
    end else begin
      thresh_q  <= thresh_d;
      timeout_q <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event counter
  // ---------------------------------------------------------------------------

  assign ev_sum   = {1'b0, rx_event_i} + {1'b0, tx_event_i};
  assign cnt_sum  = {1'b0, event_cnt_q} + (count_width_p + 1)'(ev_sum);
  assign cnt_upd  = cnt_sum[count_width_p] ? {count_width_p{1'b1}}
                                           : cnt_sum[count_width_p-1:0];
  assign ack_take = (state_q == e_irq_fire) && irq_ack_i;

  // Accumulate saturating; an accepted ack restarts from this cycle's events.
  always_comb begin
    event_cnt_d = cnt_upd;
    if (ack_take) begin
      event_cnt_d = count_width_p'(ev_sum);
    end
  end

  // Event counter state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      event_cnt_q <= '0;
    end else begin
      event_cnt_q <= event_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Timeout timer: held at zero outside COUNT, so it reads 0 on COUNT entry
  // ---------------------------------------------------------------------------

  irq_mod_timer #(
    .width_p (timer_width_p)
  ) u_timeout_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (timer_clear),
    .enable_i (1'b1),
    .count_o  (timer_q)
  );

  assign timeout_hit = (timeout_q != timer_width_p'(timeout_disabled_c)) &&
                       (timer_q == (timeout_q - timer_width_p'(1)));

  // Compare uses the count including this cycle's events.
  assign thresh_hit = (event_cnt_d >= thresh_q);

`ifdef ETHERNET_IRQ_HOLDOFF_EN
  // ---------------------------------------------------------------------------
  // Post-ack holdoff counter: zero on HOLDOFF entry, expires on its last cycle
  // ---------------------------------------------------------------------------

  localparam int unsigned hold_width_c = $clog2(holdoff_cycles_p) + 1;

  logic [hold_width_c-1:0] hold_q;
  logic                    hold_clear;
  logic                    hold_done;

  irq_mod_timer #(
    .width_p (hold_width_c)
  ) u_holdoff_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (hold_clear),
    .enable_i (1'b1),
    .count_o  (hold_q)
  );

  assign hold_done = (hold_q == hold_width_c'(holdoff_cycles_p - 1));
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register and registered interrupt request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_irq_idle;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fire_q  <= fire_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_irq_idle: begin
        if (ev_sum != 2'd0) begin
          state_d = thresh_hit ? e_irq_fire : e_irq_count;
        end
      end
      e_irq_count: begin
        if (thresh_hit || timeout_hit) begin
          state_d = e_irq_fire;
        end
      end
      e_irq_fire: begin
        if (irq_ack_i) begin
`ifdef ETHERNET_IRQ_HOLDOFF_EN
          state_d = e_irq_holdoff;
`else
          state_d = (event_cnt_d == '0) ? e_irq_idle : e_irq_count;
`endif
        end
      end
`ifdef ETHERNET_IRQ_HOLDOFF_EN
      e_irq_holdoff: begin
        if (hold_done) begin
          if (event_cnt_d == '0) begin
            state_d = e_irq_idle;
          end else if (thresh_hit) begin
            state_d = e_irq_fire;
          end else begin
            state_d = e_irq_count;
          end
        end
      end
`endif
      default: state_d = e_irq_idle;
    endcase
  end

  // Output / datapath control decoded from the FSM.
  always_comb begin
    fire_d      = (state_d == e_irq_fire);
    timer_clear = (state_q != e_irq_count);
`ifdef ETHERNET_IRQ_HOLDOFF_EN
    hold_clear  = (state_q != e_irq_holdoff);
`endif
  end

  // Enable masks only the pin; the pending FIRE state is preserved.
  assign irq_o         = fire_q & irq_enable_i;
  assign event_count_o = event_cnt_q;

endmodule

// File: tb/tb_ethernet_irq_moderator.sv
// Self-checking bench for ethernet_irq_moderator: directed scenarios with
// literal expectations plus a randomized phase checked every cycle against a
// behavioural model. Honours ETHERNET_IRQ_HOLDOFF_EN when defined.
module tb_ethernet_irq_moderator;

  localparam int CMAX = 255;
  localparam int TMAX = 65535;
`ifdef ETHERNET_IRQ_HOLDOFF_EN
  localparam int HOLD = 64;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b0, tx = 1'b0, en = 1'b1, ack = 1'b0;
  logic [7:0]  thr = 8'd0;
  logic        thr_v = 1'b0;
  logic [15:0] tmo = 16'd0;
  logic        tmo_v = 1'b0;
  logic        irq;
  logic [7:0]  cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  ethernet_irq_moderator dut (
    .clk_i           (clk),
    .reset_i         (rst),
    .rx_event_i      (rx),
    .tx_event_i      (tx),
    .irq_enable_i    (en),
    .cfg_thresh_i    (thr),
    .cfg_thresh_v_i  (thr_v),
    .cfg_timeout_i   (tmo),
    .cfg_timeout_v_i (tmo_v),
    .irq_ack_i       (ack),
    .irq_o           (irq),
    .event_count_o   (cnt)
  );

  // Behavioural model: pending flag, batch start cycle, holdoff end cycle.
  bit m_fire     = 1'b0;
  int m_cnt      = 0;
  int m_batch    = -1;  // cycle the current batch started counting, -1 = none
  int m_hold_end = -1;  // last holdoff cycle, -1 = no holdoff running
  int m_thresh   = 1;
  int m_timeout  = 0;
  int m_c        = 0;

  task automatic resolve(input int c);
    if (m_cnt == 0) begin
      m_batch = -1;
    end else if (m_cnt >= m_thresh) begin
      m_fire = 1'b1; m_batch = -1;
    end else begin
      m_batch = c + 1;
    end
  endtask

  always @(posedge clk) begin
    int ev, sum, el;
    ev  = int'(rx) + int'(tx);
    sum = m_cnt + ev;
    if (sum > CMAX) sum = CMAX;
    if (rst) begin
      m_fire = 1'b0; m_cnt = 0; m_batch = -1; m_hold_end = -1;
      m_thresh = 1; m_timeout = 0;
    end else begin
      if (m_fire) begin
        if (ack) begin
          m_fire = 1'b0; m_cnt = ev;
`ifdef ETHERNET_IRQ_HOLDOFF_EN
          m_hold_end = m_c + HOLD;
`else
          m_batch = (ev == 0) ? -1 : m_c + 1;
`endif
        end else begin
          m_cnt = sum;
        end
      end else if (m_hold_end >= 0) begin
        m_cnt = sum;
        if (m_c == m_hold_end) begin
          m_hold_end = -1;
          resolve(m_c);
        end
      end else if (m_batch < 0) begin
        m_cnt = sum;
        if (m_cnt > 0) resolve(m_c);
      end else begin
        m_cnt = sum;
        el = m_c - m_batch;
        if (el > TMAX) el = TMAX;
        if (m_cnt >= m_thresh || (m_timeout != 0 && el == m_timeout - 1)) begin
          m_fire = 1'b1; m_batch = -1;
        end
      end
      if (thr_v) m_thresh = (thr == 8'd0) ? 1 : int'(thr);
      if (tmo_v) m_timeout = int'(tmo);
    end
    m_c = m_c + 1;
  end

  task automatic lit(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rx = 1'b0; tx = 1'b0; ack = 1'b0; thr_v = 1'b0; tmo_v = 1'b0;
    en = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic cfg(input int t, input int to);
    thr = 8'(t); tmo = 16'(to); thr_v = 1'b1; tmo_v = 1'b1;
    cyc();
    thr_v = 1'b0; tmo_v = 1'b0;
  endtask

  initial begin
    // Per-cycle comparison against the model.
    fork
      forever begin
        @(negedge clk);
        if (chk_on) begin
          n_checks++;
          if (irq !== (m_fire && en)) begin
            n_fail++;
            $display("FAIL model_irq @%0t: got %b expected %b", $time, irq, m_fire && en);
          end
          n_checks++;
          if (cnt !== 8'(m_cnt)) begin
            n_fail++;
            $display("FAIL model_cnt @%0t: got %0d expected %0d", $time, cnt, m_cnt);
          end
        end
      end
    join_none

    do_reset();
    chk_on = 1'b1;
    lit("reset_irq", int'(irq), 0);
    lit("reset_cnt", int'(cnt), 0);

    // Defaults: single rx event fires next cycle; ack clears next cycle.
    repeat (3) cyc();
    rx = 1'b1; cyc(); rx = 1'b0;
    lit("t1_irq_rise", int'(irq), 1);
    lit("t1_cnt", int'(cnt), 1);
    lit("t1_model_fire", int'(m_fire), 1);
    repeat (3) cyc();
    ack = 1'b1; cyc(); ack = 1'b0;
    lit("t1_irq_ack", int'(irq), 0);
    lit("t1_cnt_ack", int'(cnt), 0);

    // Threshold 4 reached by two double pulses.
    do_reset();
    cfg(4, 0);
    rx = 1'b1; tx = 1'b1; cyc(); rx = 1'b0; tx = 1'b0;
    lit("t2_cnt2", int'(cnt), 2);
    lit("t2_irq_lo", int'(irq), 0);
    repeat (3) cyc();
    rx = 1'b1; tx = 1'b1; cyc(); rx = 1'b0; tx = 1'b0;
    lit("t2_cnt4", int'(cnt), 4);
    lit("t2_irq_hi", int'(irq), 1);
    lit("t2_model_cnt", m_cnt, 4);

    // Timeout path: thresh 8, timeout 20, one event.
    do_reset();
    cfg(8, 20);
    rx = 1'b1; cyc(); rx = 1'b0;
    repeat (19) cyc();
    lit("t3_irq_before", int'(irq), 0);
    cyc();
    lit("t3_irq_timeout", int'(irq), 1);
    lit("t3_cnt", int'(cnt), 1);

    // Saturation at 255, then ack concurrent with an rx event.
    do_reset();
    cfg(255, 0);
    rx = 1'b1;
    repeat (300) cyc();
    lit("t4_cnt_sat", int'(cnt), 255);
    lit("t4_irq", int'(irq), 1);
    ack = 1'b1; cyc(); ack = 1'b0; rx = 1'b0;
    lit("t4_cnt_reload", int'(cnt), 1);
    lit("t4_irq_ack", int'(irq), 0);

    // Masking keeps FIRE pending and counting alive.
    do_reset();
    rx = 1'b1; cyc(); rx = 1'b0;
    en = 1'b0; #1;
    lit("t5_irq_masked", int'(irq), 0);
    rx = 1'b1; cyc(); rx = 1'b0;
    lit("t5_cnt_masked", int'(cnt), 2);
    en = 1'b1; #1;
    lit("t5_irq_reexposed", int'(irq), 1);

    // Ack in IDLE is ignored.
    do_reset();
    ack = 1'b1; cyc(); ack = 1'b0;
    lit("t6_idle_ack_irq", int'(irq), 0);
    lit("t6_idle_ack_cnt", int'(cnt), 0);
    tx = 1'b1; cyc(); tx = 1'b0;
    lit("t6_irq_after", int'(irq), 1);

    // Re-fire spacing after ack with continuous events, thresh 1.
    do_reset();
    rx = 1'b1; cyc();
    lit("t7_irq_first", int'(irq), 1);
    ack = 1'b1; cyc(); ack = 1'b0;
    lit("t7_irq_ack", int'(irq), 0);
`ifdef ETHERNET_IRQ_HOLDOFF_EN
    repeat (63) cyc();
    lit("t7_irq_hold", int'(irq), 0);
    cyc();
    lit("t7_irq_refire", int'(irq), 1);
`else
    cyc();
    lit("t7_irq_refire", int'(irq), 1);
`endif
    rx = 1'b0;

    // Randomized phase.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rx    = ($urandom_range(0, 3) == 0);
      tx    = ($urandom_range(0, 3) == 0);
      ack   = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 9) != 0);
      thr_v = ($urandom_range(0, 59) == 0);
      thr   = 8'($urandom_range(0, 12));
      tmo_v = ($urandom_range(0, 59) == 0);
      tmo   = 16'($urandom_range(0, 30));
      rst   = ($urandom_range(0, 799) == 0);
      cyc();
    end
    rst = 1'b0; rx = 1'b0; tx = 1'b0; ack = 1'b0; thr_v = 1'b0; tmo_v = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ethernet_irq_moderator.md
# ethernet_irq_moderator

Interrupt moderation (coalescing) controller between the Ethernet controller's RX/TX completion events and the CPU-facing interrupt line. It counts RX-packet-arrived and TX-packet-done events and raises one interrupt when either a programmed packet threshold or a programmed timeout is reached. The interrupt is held until software acknowledges it, so each interrupt covers a batch of completions instead of one per packet. Configuration and acknowledge arrive as single-cycle CSR strobes from the controller's register decoder.

## Interface
- count_width_p, 8, width of event counter and threshold
- timer_width_p, 16, width of timeout counter and timeout value
- holdoff_cycles_p, 64, minimum quiet cycles after an acknowledge (only with the holdoff macro)

- clk_i  in  1  clock; single clock domain
- reset_i  in  1  synchronous, active-high reset
- rx_event_i  in  1  one-cycle pulse per received packet
- tx_event_i  in  1  one-cycle pulse per transmitted packet
- irq_enable_i  in  1  level; masks irq_o only, never the counting
- cfg_thresh_i  in  count_width_p  packet threshold
- cfg_thresh_v_i  in  1  write strobe for cfg_thresh_i
- cfg_timeout_i  in  timer_width_p  timeout in cycles; 0 disables the timeout
- cfg_timeout_v_i  in  1  write strobe for cfg_timeout_i
- irq_ack_i  in  1  one-cycle software acknowledge
- irq_o  out  1  moderated interrupt
- event_count_o  out  count_width_p  current accumulated event count

## Operation
- **Configuration registers**
  - thresh_r resets to 1; timeout_r resets to 0.
  - A write of thresh 0 is stored as 1.
  - A new value is used by the compare logic from the cycle after the strobe.
- **Event counter** event_cnt_r (reset 0)
  - Adds rx_event_i + tx_event_i each cycle, so +2 when both pulse in the same cycle.
  - Saturates at all-ones; no wrap-around.
- **States** (reset to IDLE):
  - IDLE: event_cnt_r == 0, timer idle.
    - Any event → FIRE if the updated count ≥ thresh_r.
    - Otherwise → COUNT, with timer_r = 0.
  - COUNT: timer_r increments by 1 each cycle and saturates.
    - → FIRE when event_cnt_r ≥ thresh_r.
    - → FIRE when timeout_r ≠ 0 and timer_r == timeout_r − 1.
    - A config write that lowers thresh_r to ≤ event_cnt_r fires on the next compare.
  - FIRE: fire_r = 1; events keep counting.
    - irq_ack_i → event_cnt_r loads only the events arriving in that cycle (0, 1 or 2).
    - Next state with ETHERNET_IRQ_HOLDOFF_EN: HOLDOFF.
    - Next state without it: IDLE if the loaded count is 0, else COUNT with timer_r = 0.
  - HOLDOFF (macro only): holdoff counter runs for holdoff_cycles_p cycles; events keep accumulating.
    - On expiry: → IDLE if the count is 0, → FIRE if count ≥ thresh_r, else → COUNT with timer_r = 0.
- irq_ack_i outside FIRE is ignored.
- irq_o = fire_r & irq_enable_i.
  - Deasserting irq_enable_i does not clear FIRE.
  - Re-enabling re-exposes the pending interrupt.
- reset_i mid-operation returns to IDLE with all counters and config at reset values.

## Timing
- All outputs are registered except the irq_enable_i gate. Reset values: irq_o 0, event_count_o 0.
- Threshold path: event in cycle t that meets the threshold → irq_o = 1 at t+1.
- Timeout path: a first event at t below the threshold → irq_o = 1 at t+1+timeout_r.
- Ack at cycle t → irq_o = 0 at t+1.
- Earliest re-fire after an ack at t:
  - With the macro: t+1+holdoff_cycles_p.
  - Without the macro: t+2 (a count loaded at the ack then meets the threshold in COUNT).
- event_count_o reflects events from cycle t at t+1.

## Configuration
- Macro ETHERNET_IRQ_HOLDOFF_EN.
- Defined: HOLDOFF state, holdoff counter and holdoff_cycles_p are compiled in. This guarantees a minimum interrupt spacing.
- Undefined: the HOLDOFF state and its counter are absent, holdoff_cycles_p is unused, and an ack goes directly to IDLE or COUNT as above.

## Structure
- Shared package ethernet_irq_mod_pkg holds:
  - the state enum (e_irq_idle, e_irq_count, e_irq_fire, e_irq_holdoff);
  - the encoding constant for "timeout disabled" (0).
- The top contains the FSM, config registers and event counter.
- Sub-module irq_mod_timer: a clear/enable saturating up-counter of parameterised width. It is instantiated once for timer_r, and once more for the holdoff counter under the macro.

## Test plan
- Reset defaults, one rx_event_i at cycle 10 → irq_o = 1 at cycle 11; ack at 15 → irq_o = 0 at 16, event_count_o = 0.
- thresh = 4, timeout = 0; rx and tx pulse together at cycles 5 and 9 → count 2 then 4; irq_o rises at cycle 10.
- thresh = 8, timeout = 20; one event at cycle 0 → irq_o rises at cycle 21, event_count_o = 1.
- Count saturation (count_width_p = 8, thresh = 255): 300 events → event_count_o holds 255 and irq fires once. Ack in the same cycle as an rx event → count reloads to 1.
- Interrupt masking: irq_enable_i = 0 while in FIRE → irq_o = 0 and count still increments; re-enable → irq_o = 1 the same cycle. An ack while in IDLE has no effect.
- With ETHERNET_IRQ_HOLDOFF_EN, holdoff_cycles_p = 64, thresh = 1: ack at cycle 100 with continuous events → next irq_o rise at cycle 165, not before.
